// File: rtl/eth_rst_seq_pkg.sv
// Shared types and 50 MHz default timing for the multi-channel Ethernet reset sequencer.
// Optional button debounce is selected with ETH_RST_SEQ_DEBOUNCE_EN.
package eth_rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // 40 ms hold, 10 ms step, 1 ms debounce at 50 MHz
  localparam int unsigned DEF_HOLD_CYCLES     = 2_000_000;
  localparam int unsigned DEF_STEP_CYCLES     = 500_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50_000;

endpackage

// File: rtl/eth_rst_debounce.sv
// Push-button synchroniser with an optional stability filter (ETH_RST_SEQ_DEBOUNCE_EN).
// Output is the accepted active-low button level; it resets to released (1).
module eth_rst_debounce
  import eth_rst_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_async,
  output logic btn_db_n
);

  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n_async;
      sync2_q <= sync1_q;
    end
  end

`ifdef ETH_RST_SEQ_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             db_q, db_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;

  // The run counter restarts whenever the synchronised level agrees with the accepted one.
  always_comb begin
    db_d   = db_q;
    dcnt_d = '0;
    if (sync2_q != db_q) begin
      if (dcnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q   <= 1'b1;
      dcnt_q <= '0;
    end else begin
      db_q   <= db_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign btn_db_n = db_q;
`else
  assign btn_db_n = sync2_q;
`endif

endmodule

// File: rtl/eth_rst_seq.sv
// Multi-channel reset sequencer: hold all outputs low, then release channel 0..NUM_CH-1 in steps.
// Button filtering is compiled in with ETH_RST_SEQ_DEBOUNCE_EN (see eth_rst_debounce).
module eth_rst_seq
  import eth_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH          = 3,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned STEP_CYCLES     = DEF_STEP_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rst_btn_n,
  input  logic              soft_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned      IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);

  logic btn_db_n;

  eth_rst_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .btn_n_async (rst_btn_n),
    .btn_db_n    (btn_db_n)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              req, hold_tc, step_tc;

  assign req     = ~btn_db_n | soft_req;
  assign hold_tc = (cnt_q == HOLD_LAST);
  assign step_tc = (cnt_q == STEP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (req) begin
      state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD: if (hold_tc) state_d = (NUM_CH == 1) ? ST_DONE : ST_STEP;
        ST_STEP: if (step_tc && (idx_q == LAST_IDX)) state_d = ST_DONE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_HOLD;
      endcase
    end
  end

  // A request overrides any release due on the same edge; the counter stays at 0 while it persists.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    if (req) begin
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          rst_n_d = '0;
          if (hold_tc) begin
            rst_n_d[0] = 1'b1;
            cnt_d      = '0;
            idx_d      = IDX_W'(1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STEP: begin
          if (step_tc) begin
            rst_n_d[idx_q] = 1'b1;
            cnt_d          = '0;
            if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          rst_n_d = '1;
          cnt_d   = '0;
        end
        default: begin
          rst_n_d = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
    done_d = (state_d == ST_DONE);
    busy_d = ~done_d;
  end

  assign rst_n_out = rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_eth_rst_seq.sv
// Scoreboard bench for eth_rst_seq: expected output snapshots are queued per edge and checked at negedge.
// Button expectations follow ETH_RST_SEQ_DEBOUNCE_EN when it is defined for the build.
module tb_eth_rst_seq;

  localparam int NUM_CH = 3;
  localparam int HOLD   = 10;
  localparam int STEP   = 4;
  localparam int DEB    = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rst_btn_n = 1'b1;
  logic              soft_req = 1'b0;
  logic [NUM_CH-1:0] rst_n_out;
  logic              busy, done;

  eth_rst_seq #(
    .NUM_CH          (NUM_CH),
    .HOLD_CYCLES     (HOLD),
    .STEP_CYCLES     (STEP),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rst_btn_n (rst_btn_n),
    .soft_req  (soft_req),
    .rst_n_out (rst_n_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_no;
    logic [2:0]  rst_n;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned ecount = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, ecount);
    end
  endtask

  // done is high exactly when every channel is released; busy is its complement.
  task automatic expect_at(input int unsigned edge_no, input logic [2:0] r, input string tag);
    exp_t e;
    e.edge_no = edge_no;
    e.rst_n   = r;
    e.tag     = tag;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].edge_no <= ecount) begin
      e = sb_q.pop_front();
      if (e.edge_no != ecount) begin
        check_val({e.tag, "_missed"}, ecount, e.edge_no);
      end else begin
        check_val({e.tag, "_rst_n"}, {29'd0, rst_n_out}, {29'd0, e.rst_n});
        check_val({e.tag, "_done"},  {31'd0, done},      {31'd0, &e.rst_n});
        check_val({e.tag, "_busy"},  {31'd0, busy},      {31'd0, ~&e.rst_n});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, t1, g, h;

    // Power-on reset
    tick(2);
    expect_at(ecount + 1, 3'b000, "reset");
    tick(1);

    // rst deasserted: releases at +10, +14, +18
    t0 = ecount;
    rst = 1'b0;
    expect_at(t0 + 9,  3'b000, "a_hold_last");
    expect_at(t0 + 10, 3'b001, "a_ch0");
    expect_at(t0 + 13, 3'b001, "a_step_last");
    expect_at(t0 + 14, 3'b011, "a_ch1");
    expect_at(t0 + 17, 3'b011, "a_pre_done");
    expect_at(t0 + 18, 3'b111, "a_ch2");
    expect_at(t0 + 19, 3'b111, "a_done_stays");
    tick(20);

    // soft_req restart, then a second pulse mid-sequence at relative edge 12
    t0 = ecount + 1;
    expect_at(t0,      3'b000, "b_soft");
    expect_at(t0 + 10, 3'b001, "b_ch0");
    expect_at(t0 + 12, 3'b001, "b_pre_pulse");
    expect_at(t0 + 13, 3'b000, "b_restart");
    expect_at(t0 + 14, 3'b000, "b_no_ch1");
    expect_at(t0 + 22, 3'b000, "b_hold_last");
    expect_at(t0 + 23, 3'b001, "b_ch0_again");
    expect_at(t0 + 27, 3'b011, "b_ch1");
    expect_at(t0 + 30, 3'b011, "b_pre_done");
    expect_at(t0 + 31, 3'b111, "b_ch2");
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    tick(12);
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    tick(20);

    // rst during STEP, then full timing repeats after release
    t0 = ecount + 1;
    t1 = t0 + 16;
    expect_at(t0,      3'b000, "c_rst");
    expect_at(t0 + 10, 3'b001, "c_ch0");
    expect_at(t0 + 14, 3'b011, "c_ch1");
    expect_at(t0 + 15, 3'b011, "c_pre_rst");
    expect_at(t0 + 16, 3'b000, "c_mid_rst");
    expect_at(t1 + 9,  3'b000, "c_hold_last");
    expect_at(t1 + 10, 3'b001, "c_ch0_again");
    expect_at(t1 + 14, 3'b011, "c_ch1_again");
    expect_at(t1 + 18, 3'b111, "c_ch2");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(15);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(20);

    // soft_req on the edge of the final release: request wins
    t0 = ecount + 1;
    t1 = t0 + 18;
    expect_at(t0,      3'b000, "d_soft");
    expect_at(t0 + 17, 3'b011, "d_pre_final");
    expect_at(t1,      3'b000, "d_coincident");
    expect_at(t1 + 9,  3'b000, "d_hold_last");
    expect_at(t1 + 10, 3'b001, "d_ch0");
    expect_at(t1 + 14, 3'b011, "d_ch1");
    expect_at(t1 + 18, 3'b111, "d_ch2");
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    tick(17);
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    tick(20);

`ifdef ETH_RST_SEQ_DEBOUNCE_EN
    // 3-cycle glitch is filtered out
    g = ecount;
    expect_at(g + 6,  3'b111, "e_glitch_mid");
    expect_at(g + 12, 3'b111, "e_glitch_after");
    rst_btn_n = 1'b0;
    tick(3);
    rst_btn_n = 1'b1;
    tick(12);

    // 20-cycle press: outputs low after 2+5+1 edges, release 10 edges after debounced rise
    h = ecount;
    expect_at(h + 7,  3'b111, "e_press_pre");
    expect_at(h + 8,  3'b000, "e_press");
    expect_at(h + 30, 3'b000, "e_held");
    expect_at(h + 36, 3'b000, "e_hold_last");
    expect_at(h + 37, 3'b001, "e_ch0");
    expect_at(h + 41, 3'b011, "e_ch1");
    expect_at(h + 45, 3'b111, "e_ch2");
    rst_btn_n = 1'b0;
    tick(20);
    rst_btn_n = 1'b1;
    tick(48);
`else
    // Single-cycle press restarts the sequence three edges later
    g = ecount;
    t0 = g + 3;
    expect_at(g + 2,   3'b111, "e_press_pre");
    expect_at(t0,      3'b000, "e_press");
    expect_at(t0 + 9,  3'b000, "e_hold_last");
    expect_at(t0 + 10, 3'b001, "e_ch0");
    expect_at(t0 + 14, 3'b011, "e_ch1");
    expect_at(t0 + 18, 3'b111, "e_ch2");
    rst_btn_n = 1'b0;
    tick(1);
    rst_btn_n = 1'b1;
    tick(24);
`endif

    if (sb_q.size() != 0) check_val("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
